// File: rtl/session_pkg.sv
// Shared types and defaults for the session controller and its timers.
package session_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        LOGOUT    = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REASON_NONE    = 2'd0,
        REASON_BTN     = 2'd1,
        REASON_TIMEOUT = 2'd2,
        REASON_GUEST   = 2'd3
    } reason_t;

    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_GUEST_ROUNDS   = 3;
    localparam int DEF_ACK_CYCLES     = 16;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/session_timer.sv
// Loadable up-counter with clear, load, enable and a terminal-count flag.
module session_timer #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == TERMINAL);

endmodule

// File: rtl/session_ctrl.sv
// Logged-in session supervisor: gates the game and issues logout pulses to Authentication.
module session_ctrl
    import session_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GUEST_ROUNDS   = DEF_GUEST_ROUNDS,
    parameter int ACK_CYCLES     = DEF_ACK_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       log_in_ctrl,
    input  logic       isGuest_ctrl,
    input  logic [2:0] intID_ctrl,
    input  logic       logout_btn,
    input  logic       game_activity,
    input  logic       round_done,
    output logic       log_out_ctrl,
    output logic       session_active,
    output logic       game_enable,
    output logic [2:0] user_id,
    output logic       is_guest,
    output logic [7:0] rounds_played,
    output logic [1:0] logout_reason
);

    localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);
    localparam int ACK_W  = cnt_width(ACK_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACK_W-1:0]  ACK_TERM  = ACK_W'(ACK_CYCLES - 1);

    state_t     state_reg, state_next;
    reason_t    reason_reg, reason_next;
    logic [7:0] rounds_reg, rounds_next;
    logic [2:0] user_reg, user_next;
    logic       guest_reg, guest_next;
    logic       btn_prev_reg;
    logic       pulse_reg;
    logic       active_reg;
    logic       btn_rise;
    logic       idle_terminal;
    logic       ack_terminal;

    assign btn_rise = logout_btn & ~btn_prev_reg;

    // Idle counter runs only in ACTIVE; it sits at zero everywhere else so entry starts fresh.
    session_timer #(.WIDTH(IDLE_W), .TERMINAL(IDLE_TERM)) idle_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state_reg != ACTIVE) || game_activity),
        .load       (1'b0),
        .load_value ('0),
        .enable     (state_reg == ACTIVE),
        .terminal   (idle_terminal)
    );

    session_timer #(.WIDTH(ACK_W), .TERMINAL(ACK_TERM)) ack_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg != WAIT_DROP),
        .load       (1'b0),
        .load_value ('0),
        .enable     (log_in_ctrl),
        .terminal   (ack_terminal)
    );

    always_comb begin
        state_next  = state_reg;
        reason_next = reason_reg;
        rounds_next = rounds_reg;
        user_next   = user_reg;
        guest_next  = guest_reg;
        unique case (state_reg)
            IDLE: begin
                if (log_in_ctrl) begin
                    state_next  = ACTIVE;
                    user_next   = intID_ctrl;
                    guest_next  = isGuest_ctrl;
                    rounds_next = '0;
                    reason_next = REASON_NONE;
                end
            end
            ACTIVE: begin
                if (round_done && rounds_reg != 8'hFF) begin
                    rounds_next = rounds_reg + 8'd1;
                end
                if (!log_in_ctrl) begin
                    state_next  = IDLE;
                    reason_next = REASON_NONE;
                end else if (btn_rise) begin
                    state_next  = LOGOUT;
                    reason_next = REASON_BTN;
                end else if (idle_terminal && !game_activity) begin
                    state_next  = LOGOUT;
                    reason_next = REASON_TIMEOUT;
                end else if (guest_reg && int'(rounds_next) >= GUEST_ROUNDS) begin
                    state_next  = LOGOUT;
                    reason_next = REASON_GUEST;
                end
            end
            LOGOUT: begin
                state_next = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!log_in_ctrl) begin
                    state_next = IDLE;
                end else if (ack_terminal) begin
                    state_next = LOGOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            reason_reg   <= REASON_NONE;
            rounds_reg   <= '0;
            user_reg     <= '0;
            guest_reg    <= 1'b0;
            btn_prev_reg <= 1'b0;
            pulse_reg    <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            reason_reg   <= reason_next;
            rounds_reg   <= rounds_next;
            user_reg     <= user_next;
            guest_reg    <= guest_next;
            btn_prev_reg <= logout_btn;
            pulse_reg    <= (state_next == LOGOUT);
            active_reg   <= (state_next == ACTIVE);
        end
    end

    assign log_out_ctrl   = pulse_reg;
    assign session_active = active_reg;
    assign game_enable    = active_reg;
    assign user_id        = user_reg;
    assign is_guest       = guest_reg;
    assign rounds_played  = rounds_reg;
    assign logout_reason  = reason_reg;

endmodule

// File: tb/tb_session_ctrl.sv
// Self-checking bench for session_ctrl: vector table, directed corner cases, random traffic vs. a timing model.
module tb_session_ctrl;

    localparam int T = 1024;
    localparam int G = 3;
    localparam int A = 16;

    logic       clk = 1'b0;
    logic       rst, log_in_ctrl, isGuest_ctrl, logout_btn, game_activity, round_done;
    logic [2:0] intID_ctrl;
    logic       log_out_ctrl, session_active, game_enable, is_guest;
    logic [2:0] user_id;
    logic [7:0] rounds_played;
    logic [1:0] logout_reason;

    session_ctrl #(.TIMEOUT_CYCLES(T), .GUEST_ROUNDS(G), .ACK_CYCLES(A)) dut (
        .clk            (clk),
        .rst            (rst),
        .log_in_ctrl    (log_in_ctrl),
        .isGuest_ctrl   (isGuest_ctrl),
        .intID_ctrl     (intID_ctrl),
        .logout_btn     (logout_btn),
        .game_activity  (game_activity),
        .round_done     (round_done),
        .log_out_ctrl   (log_out_ctrl),
        .session_active (session_active),
        .game_enable    (game_enable),
        .user_id        (user_id),
        .is_guest       (is_guest),
        .rounds_played  (rounds_played),
        .logout_reason  (logout_reason)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: session described by timestamps (login/activity edge, last pulse edge).
    int         m_mode = 0;   // 0 logged out, 1 in session, 2 after logout pulse
    int         m_edge = 0;
    int         t_act = 0;
    int         t_pulse = 0;
    int         m_rounds = 0;
    bit         m_prev_btn = 0;
    bit         e_pulse = 0, e_active = 0, e_guest = 0;
    logic [2:0] e_user = '0;
    logic [1:0] e_reason = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, m_edge);
        end
    endtask

    task automatic model_step();
        bit rise;
        m_edge++;
        rise = logout_btn && !m_prev_btn;
        if (rst) begin
            m_mode = 0; m_rounds = 0; e_pulse = 0; e_active = 0;
            e_user = '0; e_guest = 0; e_reason = '0; m_prev_btn = 0;
            return;
        end
        m_prev_btn = logout_btn;
        e_pulse = 0;
        if (m_mode == 0) begin
            if (log_in_ctrl) begin
                m_mode = 1; e_active = 1; e_user = intID_ctrl; e_guest = isGuest_ctrl;
                m_rounds = 0; e_reason = 0; t_act = m_edge;
            end
        end else if (m_mode == 1) begin
            if (round_done && m_rounds < 255) m_rounds++;
            if (!log_in_ctrl) begin
                m_mode = 0; e_active = 0; e_reason = 0;
            end else begin
                int why;
                why = 0;
                if (rise) why = 1;
                else if (!game_activity && (m_edge - t_act == T)) why = 2;
                else if (e_guest && m_rounds >= G) why = 3;
                if (why != 0) begin
                    m_mode = 2; e_active = 0; e_pulse = 1; e_reason = 2'(why); t_pulse = m_edge;
                end
            end
            if (game_activity) t_act = m_edge;
        end else begin
            if (m_edge == t_pulse + 1) begin
                // the pulse cycle itself ignores inputs
            end else if (!log_in_ctrl) begin
                m_mode = 0;
            end else if (m_edge - t_pulse == A + 1) begin
                e_pulse = 1; t_pulse = m_edge;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("log_out_ctrl", 32'(log_out_ctrl), 32'(e_pulse));
        chk("session_active", 32'(session_active), 32'(e_active));
        chk("game_enable", 32'(game_enable), 32'(e_active));
        chk("user_id", 32'(user_id), 32'(e_user));
        chk("is_guest", 32'(is_guest), 32'(e_guest));
        chk("rounds_played", 32'(rounds_played), 32'(m_rounds));
        chk("logout_reason", 32'(logout_reason), 32'(e_reason));
    endtask

    task automatic idle_inputs();
        rst = 0; logout_btn = 0; game_activity = 0; round_done = 0;
    endtask

    task automatic do_login(input logic [2:0] id, input logic guest);
        log_in_ctrl = 1; intID_ctrl = id; isGuest_ctrl = guest;
        tick();
    endtask

    task automatic do_drop();
        log_in_ctrl = 0;
        tick(); tick();
    endtask

    typedef struct {
        logic       rst, login, guest;
        logic [2:0] id;
        logic       btn, act, rd;
        logic       pulse, active;
        logic [2:0] user;
        logic       g;
        logic [7:0] rounds;
        logic [1:0] reason;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic r, input logic li, input logic gu, input int id,
                                input logic b, input logic ac, input logic rd,
                                input logic p, input logic a, input int u, input logic g,
                                input int rn, input int rs);
        vec_t v;
        v.rst = r; v.login = li; v.guest = gu; v.id = 3'(id); v.btn = b; v.act = ac; v.rd = rd;
        v.pulse = p; v.active = a; v.user = 3'(u); v.g = g; v.rounds = 8'(rn); v.reason = 2'(rs);
        return v;
    endfunction

    initial begin
        int n, last, gap;
        rst = 1; log_in_ctrl = 0; isGuest_ctrl = 0; intID_ctrl = '0;
        logout_btn = 0; game_activity = 0; round_done = 0;

        //             rst li gu id b  ac rd   p  a  u  g  rn rs
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 2, 0, 0, 0,   0, 1, 2, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 2, 1, 0, 0,   1, 0, 2, 0, 0, 1);
        vecs[3]  = mk(0, 1, 0, 2, 1, 0, 0,   0, 0, 2, 0, 0, 1);
        vecs[4]  = mk(0, 1, 0, 2, 1, 0, 0,   0, 0, 2, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 2, 0, 0, 0,   0, 0, 2, 0, 0, 1);
        vecs[6]  = mk(0, 1, 1, 5, 0, 0, 0,   0, 1, 5, 1, 0, 0);
        vecs[7]  = mk(0, 1, 1, 5, 0, 0, 1,   0, 1, 5, 1, 1, 0);
        vecs[8]  = mk(0, 1, 1, 5, 0, 1, 1,   0, 1, 5, 1, 2, 0);
        vecs[9]  = mk(0, 1, 1, 5, 0, 0, 1,   1, 0, 5, 1, 3, 3);
        vecs[10] = mk(0, 0, 1, 5, 0, 0, 0,   0, 0, 5, 1, 3, 3);
        vecs[11] = mk(0, 0, 1, 5, 0, 0, 0,   0, 0, 5, 1, 3, 3);
        vecs[12] = mk(0, 1, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 0);
        vecs[13] = mk(1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 7, 0, 0, 0,   0, 1, 7, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 7, 0, 0, 0,   0, 0, 7, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; log_in_ctrl = vecs[i].login; isGuest_ctrl = vecs[i].guest;
            intID_ctrl = vecs[i].id; logout_btn = vecs[i].btn; game_activity = vecs[i].act;
            round_done = vecs[i].rd;
            tick();
            chk("vec_pulse", 32'(log_out_ctrl), 32'(vecs[i].pulse));
            chk("vec_active", 32'(session_active), 32'(vecs[i].active));
            chk("vec_user", 32'(user_id), 32'(vecs[i].user));
            chk("vec_guest", 32'(is_guest), 32'(vecs[i].g));
            chk("vec_rounds", 32'(rounds_played), 32'(vecs[i].rounds));
            chk("vec_reason", 32'(logout_reason), 32'(vecs[i].reason));
            $display("vector %0d: pulse=%0d active=%0d user=%0d guest=%0d rounds=%0d reason=%0d",
                     i, log_out_ctrl, session_active, user_id, is_guest, rounds_played, logout_reason);
        end
        idle_inputs();

        // Held button counts once.
        do_login(3'd2, 1'b0);
        chk("login_active", 32'(session_active), 32'd1);
        chk("login_user", 32'(user_id), 32'd2);
        n = 0;
        logout_btn = 1;
        for (int i = 0; i < 9; i++) begin tick(); if (log_out_ctrl) n++; end
        logout_btn = 0;
        chk("btn_pulse_count", 32'(n), 32'd1);
        chk("btn_reason", 32'(logout_reason), 32'd1);
        tick(); tick();
        do_drop();
        chk("btn_idle", 32'(session_active), 32'd0);
        $display("button sequence: pulses=%0d reason=%0d", n, logout_reason);

        // Guest round limit with periodic activity.
        do_login(3'd4, 1'b1);
        for (int i = 0; i < 300; i++) begin
            game_activity = (i % 100 == 50);
            round_done    = (i % 100 == 99);
            tick();
            if (i < 299) chk("guest_no_early_pulse", 32'(log_out_ctrl), 32'd0);
        end
        idle_inputs();
        chk("guest_pulse", 32'(log_out_ctrl), 32'd1);
        chk("guest_reason", 32'(logout_reason), 32'd3);
        chk("guest_rounds", 32'(rounds_played), 32'd3);
        $display("guest sequence: pulse=%0d reason=%0d rounds=%0d", log_out_ctrl, logout_reason, rounds_played);
        do_drop();

        // Inactivity timeout, plain and with one late activity pulse.
        for (int k = 0; k < 2; k++) begin
            do_login(3'd6, 1'b0);
            n = 0;
            while (!log_out_ctrl && n < 3000) begin
                n++;
                game_activity = (k == 1 && n == 1001);
                tick();
                game_activity = 0;
            end
            chk(k == 0 ? "timeout_cycles" : "timeout_delayed", 32'(n), 32'(k == 0 ? T : T + 1001));
            chk("timeout_reason", 32'(logout_reason), 32'd2);
            $display("timeout sequence %0d: pulse after %0d cycles", k, n);
            if (k == 0) do_drop();
        end

        // Re-pulse while Authentication keeps log_in_ctrl high.
        last = 0; n = 0;
        for (int i = 1; i <= 3 * (A + 1) + 2; i++) begin
            tick();
            if (log_out_ctrl) begin
                gap = i - last; last = i; n++;
                chk("repulse_gap", 32'(gap), 32'(A + 1));
                $display("re-pulse %0d after %0d cycles", n, gap);
            end
        end
        chk("repulse_count", 32'(n), 32'd3);
        do_drop();
        chk("after_repulse_idle", 32'(session_active), 32'd0);
        do_login(3'd3, 1'b0);
        chk("relogin_active", 32'(session_active), 32'd1);

        // Reset mid-ACTIVE, then mid-WAIT_DROP.
        tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_active_pulse", 32'(log_out_ctrl), 32'd0);
        chk("rst_active_session", 32'(session_active), 32'd0);
        chk("rst_active_user", 32'(user_id), 32'd0);
        tick();
        logout_btn = 1; tick(); logout_btn = 0; tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_wait_pulse", 32'(log_out_ctrl), 32'd0);
        chk("rst_wait_reason", 32'(logout_reason), 32'd0);
        $display("reset sequences: session=%0d reason=%0d", session_active, logout_reason);
        do_drop();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) log_in_ctrl = ~log_in_ctrl;
            intID_ctrl    = 3'($urandom_range(0, 7));
            isGuest_ctrl  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) logout_btn = ~logout_btn;
            game_activity = ($urandom_range(0, 7) == 0);
            round_done    = ($urandom_range(0, 9) == 0);
            tick();
        end
        $display("random phase complete: %0d edges", m_edge);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/session_ctrl.md
Name: session_ctrl

Overview:
- Game-controller-side partner of the Authentication block.
- Consumes log_in_ctrl, isGuest_ctrl and intID_ctrl, then runs the logged-in session and gates the game.
- Generates the log_out_ctrl pulse that returns Authentication to its ID-entry state.
- Logout causes: user logout button, inactivity timeout, or guest round limit.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles (no game_activity) before forced logout.
- GUEST_ROUNDS, 3: completed rounds allowed for a guest session before forced logout.
- ACK_CYCLES, 16: cycles to wait for log_in_ctrl to drop after a logout pulse before re-pulsing.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- log_in_ctrl  input  1  level from Authentication; high while a user is logged in.
- isGuest_ctrl  input  1  guest flag from Authentication; valid while log_in_ctrl is high.
- intID_ctrl  input  3  user index from Authentication; valid while log_in_ctrl is high.
- logout_btn  input  1  debounced, synchronized push-button level; active-high.
- game_activity  input  1  one-cycle pulse on any player action.
- round_done  input  1  one-cycle pulse when a game round completes.
- log_out_ctrl  output  1  one-cycle logout pulse to Authentication.
- session_active  output  1  high while in ACTIVE.
- game_enable  output  1  enables the game datapath; equals session_active.
- user_id  output  3  latched intID_ctrl.
- is_guest  output  1  latched isGuest_ctrl.
- rounds_played  output  8  completed rounds this session; saturates at 255.
- logout_reason  output  2  0 none, 1 button, 2 timeout, 3 guest limit.

Behaviour:
- All outputs are registered.
- Reset values: log_out_ctrl=0, session_active=0, game_enable=0, user_id=0, is_guest=0, rounds_played=0, logout_reason=0; state=IDLE; idle counter, ack counter and button edge register cleared.
- rst asserted in any state, including mid-session or mid-pulse: next cycle is the reset state. No logout pulse is issued for a reset.
- logout_btn uses rising-edge detect only; a held button counts once.
- IDLE:
  - If log_in_ctrl=1 at edge N, latch user_id and is_guest, clear rounds_played, idle counter and logout_reason.
  - Go to ACTIVE; session_active and game_enable are high from edge N.
- ACTIVE:
  - idle counter increments each cycle and clears on game_activity.
  - round_done increments rounds_played, saturating at 255.
  - Exit conditions, in priority order when simultaneous:
    - log_in_ctrl=0 (authentication dropped externally): to IDLE, no pulse, reason=0.
    - logout_btn rising edge: LOGOUT, reason=1.
    - idle counter == TIMEOUT_CYCLES-1 without game_activity this cycle: LOGOUT, reason=2.
    - is_guest=1 and rounds_played reaches GUEST_ROUNDS (including on the round_done cycle): LOGOUT, reason=3.
  - Events coinciding with an exit are still applied on that edge; events after the exit are ignored.
- LOGOUT (1 cycle):
  - log_out_ctrl=1; session_active and game_enable drop on the same edge.
  - Clear ack counter, go to WAIT_DROP.
- WAIT_DROP:
  - log_out_ctrl=0.
  - If log_in_ctrl=0: go to IDLE. logout_reason, user_id and rounds_played hold until the next login.
  - Otherwise increment the ack counter; at ACK_CYCLES-1 return to LOGOUT (re-pulse). Retries are unlimited.
- A new login is never accepted in WAIT_DROP.
- Counter widths: idle counter is clog2(TIMEOUT_CYCLES); ack counter is clog2(ACK_CYCLES). Neither wraps: both clear on state entry.

Decomposition:
- Package session_pkg holds:
  - state encoding IDLE=0, ACTIVE=1, LOGOUT=2, WAIT_DROP=3;
  - logout_reason codes REASON_NONE, REASON_BTN, REASON_TIMEOUT, REASON_GUEST;
  - default parameter constants.
- Sub-module session_timer: a loadable up-counter with clear, enable and terminal-count flag, parameterized by terminal value.
- session_timer is instanced twice: idle timeout and ack wait.

Test Plan:
- Reset, then log_in_ctrl=1 with intID_ctrl=3'd2, isGuest_ctrl=0 -> session_active=1 one cycle later, user_id=2, is_guest=0, log_out_ctrl stays 0.
- In ACTIVE, logout_btn high for 9 cycles -> exactly one log_out_ctrl pulse, logout_reason=1. Drop log_in_ctrl 2 cycles later -> IDLE.
- Guest login (isGuest_ctrl=1), three round_done pulses with game_activity every 100 cycles -> log_out_ctrl pulse on the cycle after the 3rd round_done, reason=3, rounds_played=3.
- Registered login with no game_activity -> log_out_ctrl pulse exactly TIMEOUT_CYCLES cycles after entering ACTIVE, reason=2. A game_activity pulse at cycle 1000 delays the pulse by 1001 cycles.
- After a logout pulse, hold log_in_ctrl=1 -> re-pulse every ACK_CYCLES+1 cycles until it drops. Then IDLE; a new login is accepted.
- Assert rst mid-ACTIVE and again during WAIT_DROP -> all outputs return to their reset values on the next edge, with no log_out_ctrl pulse.
